// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared encodings and width helpers for the streaming Sobel filter
package sobel_pkg;

  typedef enum logic [1:0] {
    MODE_SUM  = 2'd0,
    MODE_GX   = 2'd1,
    MODE_GY   = 2'd2,
    MODE_PASS = 2'd3
  } mode_e;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam int GRAD_EXTRA = 3;
  localparam int MAG_EXTRA  = 4;

  function automatic int grad_w(input int pix_w);
    return pix_w + GRAD_EXTRA;
  endfunction

  function automatic int mag_w(input int pix_w);
    return pix_w + MAG_EXTRA;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// rtl/sobel_line_buffer.sv - enabled shift-register delay line, one image row deep
module sobel_line_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else if (en) begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/sobel_stream.sv
// rtl/sobel_stream.sv - streaming 3x3 Sobel edge detector with backpressure and end-of-frame flush
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int PIX_W = 8,
  parameter int SHIFT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int GRAD_W    = grad_w(PIX_W);
  localparam int MAG_W     = mag_w(PIX_W);
  localparam int TOTAL     = IMG_W * IMG_H;
  localparam int ADV_TOTAL = TOTAL + IMG_W + 1;
  localparam int CNT_W     = $clog2(ADV_TOTAL + 1);
  localparam int ROW_W     = $clog2(IMG_H + 1);
  localparam int COL_W     = $clog2(IMG_W);

  state_e             state_q, state_d;
  mode_e              mode_q;
  logic               ready_en;
  logic [CNT_W-1:0]   in_cnt;
  logic [ROW_W-1:0]   orow;
  logic [COL_W-1:0]   ocol;
  logic               adv, accept, produce, frame_done;
  logic [PIX_W-1:0]   push_pix, lb0_out, lb1_out;
  logic [PIX_W-1:0]   win  [3][3];
  logic [PIX_W-1:0]   nwin [3][3];
  logic [PIX_W-1:0]   col_new [3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    adv      = 1'b0;
    accept   = 1'b0;
    case (state_q)
      RUN: begin
        in_ready = ready_en && (!out_valid || out_ready);
        accept   = in_ready && in_valid;
        adv      = accept;
        if (accept && in_cnt == CNT_W'(TOTAL - 1)) state_d = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        // stop advancing once the last output has been produced
        adv  = (in_cnt != CNT_W'(ADV_TOTAL)) && (!out_valid || out_ready);
        if (out_valid && out_ready && out_last) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign produce    = adv && (state_q == FLUSH || in_cnt >= CNT_W'(IMG_W + 1));
  assign frame_done = (state_q == FLUSH) && out_valid && out_ready && out_last;
  assign push_pix   = (state_q == RUN) ? in_data : '0;

  sobel_line_buffer #(.WIDTH(PIX_W), .DEPTH(IMG_W)) u_lb0 (
    .clk  (clk),
    .rst  (rst),
    .en   (adv),
    .din  (push_pix),
    .dout (lb0_out)
  );

  sobel_line_buffer #(.WIDTH(PIX_W), .DEPTH(IMG_W)) u_lb1 (
    .clk  (clk),
    .rst  (rst),
    .en   (adv),
    .din  (lb0_out),
    .dout (lb1_out)
  );

  // result is computed from the window as it will be after this advance
  always_comb begin
    col_new[0] = lb1_out;
    col_new[1] = lb0_out;
    col_new[2] = push_pix;
    for (int r = 0; r < 3; r++) begin
      nwin[r][0] = win[r][1];
      nwin[r][1] = win[r][2];
      nwin[r][2] = col_new[r];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win[r][c] <= '0;
    end else if (frame_done) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win[r][c] <= '0;
    end else if (adv) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win[r][c] <= nwin[r][c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en <= 1'b0;
      in_cnt   <= '0;
      orow     <= '0;
      ocol     <= '0;
      mode_q   <= MODE_SUM;
    end else begin
      ready_en <= 1'b1;
      if (frame_done) begin
        in_cnt <= '0;
        orow   <= '0;
        ocol   <= '0;
      end else if (adv) begin
        in_cnt <= in_cnt + 1'b1;
        if (accept && in_cnt == '0) mode_q <= mode_e'(mode);
        if (produce) begin
          if (ocol == COL_W'(IMG_W - 1)) begin
            ocol <= '0;
            orow <= orow + 1'b1;
          end else begin
            ocol <= ocol + 1'b1;
          end
        end
      end
    end
  end

  function automatic logic signed [GRAD_W-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({{GRAD_EXTRA{1'b0}}, p});
  endfunction

  logic signed [GRAD_W-1:0] gx, gy, gx_abs, gy_abs;
  logic [MAG_W-1:0]         mag, mag_sh;
  logic [PIX_W-1:0]         sat, result;
  logic                     border;

  always_comb begin
    gx = (ext(nwin[0][2]) + (ext(nwin[1][2]) <<< 1) + ext(nwin[2][2]))
       - (ext(nwin[0][0]) + (ext(nwin[1][0]) <<< 1) + ext(nwin[2][0]));
    gy = (ext(nwin[2][0]) + (ext(nwin[2][1]) <<< 1) + ext(nwin[2][2]))
       - (ext(nwin[0][0]) + (ext(nwin[0][1]) <<< 1) + ext(nwin[0][2]));
    gx_abs = gx[GRAD_W-1] ? -gx : gx;
    gy_abs = gy[GRAD_W-1] ? -gy : gy;
    case (mode_q)
      MODE_SUM: mag = {1'b0, gx_abs} + {1'b0, gy_abs};
      MODE_GX:  mag = {1'b0, gx_abs};
      MODE_GY:  mag = {1'b0, gy_abs};
      default:  mag = '0;
    endcase
    mag_sh = mag >> SHIFT;
    sat    = (|mag_sh[MAG_W-1:PIX_W]) ? {PIX_W{1'b1}} : mag_sh[PIX_W-1:0];
    border = (orow == '0) || (orow == ROW_W'(IMG_H - 1)) ||
             (ocol == '0) || (ocol == COL_W'(IMG_W - 1));
    if (mode_q == MODE_PASS) result = nwin[1][1];
    else if (border)         result = '0;
    else                     result = sat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (produce) begin
      out_valid <= 1'b1;
      out_data  <= result;
      out_last  <= (orow == ROW_W'(IMG_H - 1)) && (ocol == COL_W'(IMG_W - 1));
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// tb/tb_sobel_stream.sv - directed self-checking bench for sobel_stream on an 8x6 frame
module tb_sobel_stream;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  int total = 0;
  int passed = 0;
  int got_data[$];
  int got_last[$];
  int got_busy[$];
  bit rand_ready = 1'b0;
  bit stalled = 1'b0;
  int held = 0;

  always #5 clk = ~clk;

  sobel_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .SHIFT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int pix(input int kind, input int v, input int idx);
    int c;
    c = idx % W;
    case (kind)
      0:       return v;
      1:       return (c < 4) ? 0 : 200;
      default: return 10 * c;
    endcase
  endfunction

  function automatic int expv(input int kind, input int v, input int md, input int idx);
    int r, c;
    r = idx / W;
    c = idx % W;
    if (md == 3) return pix(kind, v, idx);
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
    if (kind == 0 || md == 2) return 0;
    if (kind == 1) return (c == 3 || c == 4) ? 255 : 0;
    return 40;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_data", int'(out_data), held);
      end
      if (out_valid && out_ready) begin
        got_data.push_back(int'(out_data));
        got_last.push_back(int'(out_last));
        got_busy.push_back(int'(busy));
      end
      stalled = out_valid && !out_ready;
      held    = int'(out_data);
    end
  end

  task automatic send_frame(input int kind, input int v, input bit gaps, input int md,
                            input int sw_at, input int md2, input int stop_at);
    bit acc;
    got_data.delete();
    got_last.delete();
    got_busy.delete();
    mode = md[1:0];
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (k == stop_at) break;
      if (k == sw_at) mode = md2[1:0];
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data  = 8'(pix(kind, v, k));
      acc = 1'b0;
      for (int t = 0; t < 300 && !acc; t++) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
      end
      if (!acc) begin
        check("accept_bound", int'(acc), 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int kind, input int v, input int md);
    for (int t = 0; t < 2000 && got_data.size() < N; t++) @(posedge clk);
    repeat (20) @(posedge clk);
    check({tag, "_count"}, got_data.size(), N);
    for (int i = 0; i < N && i < got_data.size(); i++) begin
      check($sformatf("%s_data[%0d]", tag, i), got_data[i], expv(kind, v, md, i));
      check($sformatf("%s_last[%0d]", tag, i), got_last[i], (i == N - 1) ? 1 : 0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_before_edge", int'(in_ready), 0);
    @(negedge clk);
    check("ready_after_edge", int'(in_ready), 1);

    send_frame(0, 100, 1'b0, 0, -1, 0, -1);
    check_frame("flat100_sum", 0, 100, 0);
    for (int i = N - W - 1; i < N; i++)
      check($sformatf("busy_flush[%0d]", i), got_busy[i], 1);
    check("busy_run", got_busy[N - W - 3], 0);
    @(negedge clk);
    check("busy_idle", int'(busy), 0);

    send_frame(1, 0, 1'b0, 1, -1, 1, -1);
    check_frame("edge_gx", 1, 0, 1);
    send_frame(1, 0, 1'b0, 2, -1, 2, -1);
    check_frame("edge_gy", 1, 0, 2);
    send_frame(2, 0, 1'b0, 1, -1, 1, -1);
    check_frame("ramp_gx", 2, 0, 1);
    send_frame(2, 0, 1'b0, 0, -1, 0, -1);
    check_frame("ramp_sum", 2, 0, 0);
    send_frame(2, 0, 1'b0, 3, -1, 3, -1);
    check_frame("ramp_pass", 2, 0, 3);

    rand_ready = 1'b1;
    send_frame(2, 0, 1'b1, 3, -1, 3, -1);
    check_frame("ramp_pass_stall", 2, 0, 3);
    send_frame(2, 0, 1'b1, 1, -1, 1, -1);
    check_frame("ramp_gx_stall", 2, 0, 1);
    rand_ready = 1'b0;

    send_frame(0, 100, 1'b0, 0, -1, 0, 20);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_frame(0, 50, 1'b0, 0, -1, 0, -1);
    check_frame("flat50_after_rst", 0, 50, 0);

    send_frame(2, 0, 1'b0, 1, 10, 3, -1);
    check_frame("mode_switch_mid", 2, 0, 1);
    send_frame(2, 0, 1'b0, 3, -1, 3, -1);
    check_frame("mode_next_frame", 2, 0, 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
